// File: rtl/psl_bw_pkg.sv
// Shared types and helpers for the PSL buffer-write line assembler.
package psl_bw_pkg;

  localparam int HALF_W         = 512;
  localparam int LINE_W         = 1024;
  localparam int WORDS_PER_HALF = 8;
  // Widest tag a FIFO entry can carry; narrower tags are zero-extended.
  localparam int MAX_TAG_W      = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    HALF1 = 1'b1
  } state_e;

  typedef struct packed {
    logic [MAX_TAG_W-1:0] tag;
    logic [0:LINE_W-1]    data;
    logic                 perr;
  } line_entry_t;

  function automatic logic odd_par_ok(input logic [63:0] data64, input logic par);
    return (^data64 ^ par) == 1'b1;
  endfunction

endpackage

// File: rtl/psl_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; a push while full is only
// accepted when a pop happens on the same edge.
module psl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_dout  = r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
      else if (w_rd && !w_wr) r_count <= r_count - 1'b1;
    end
  end

  // Storage is not reset: the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/psl_bw_line_assembler.sv
// Reassembles PSL buffer-write half-line beats into tagged 1024-bit lines.
// Parity checking is built only when PSL_BW_PARITY_CHECK_EN is defined.
module psl_bw_line_assembler
  import psl_bw_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic                   ha_pclock,
  input  logic                   ha_preset_n,
  input  logic                   ha_bwvalid,
  input  logic [TAG_W-1:0]       ha_bwtag,
  input  logic                   ha_bwtagpar,
  input  logic [5:0]             ha_bwad,
  input  logic [0:HALF_W-1]      ha_bwdata,
  input  logic [0:7]             ha_bwpar,
  output logic                   line_valid,
  input  logic                   line_ready,
  output logic [TAG_W-1:0]       line_tag,
  output logic [0:LINE_W-1]      line_data,
  output logic                   line_perr,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   proto_err
);

  state_e            r_state, w_state_nxt;
  logic [TAG_W-1:0]  r_tag;
  logic [0:HALF_W-1] r_half0;
  logic              r_perr0;
  logic              r_proto_err;
  logic              r_overflow;

  logic              w_cap0, w_complete, w_proto;
  logic              w_beat_perr;
  logic              w_full, w_empty, w_pop;
  line_entry_t       w_wr_entry, w_head;

`ifdef PSL_BW_PARITY_CHECK_EN
  always_comb begin
    w_beat_perr = !odd_par_ok(64'(ha_bwtag), ha_bwtagpar);
    for (int i = 0; i < WORDS_PER_HALF; i++)
      if (!odd_par_ok(ha_bwdata[64*i +: 64], ha_bwpar[i])) w_beat_perr = 1'b1;
  end
  assign line_perr = ~w_empty & w_head.perr;
`else
  logic w_unused_par;
  assign w_beat_perr  = 1'b0;
  assign w_unused_par = ^{ha_bwpar, ha_bwtagpar, w_head.perr};
  assign line_perr    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cap0      = 1'b0;
    w_complete  = 1'b0;
    w_proto     = 1'b0;
    if (ha_bwvalid) begin
      if (ha_bwad > 6'd1) begin
        w_proto = 1'b1;
      end else if (r_state == IDLE) begin
        if (ha_bwad == 6'd0) begin
          w_cap0      = 1'b1;
          w_state_nxt = HALF1;
        end else begin
          w_proto = 1'b1;
        end
      end else if (ha_bwad == 6'd0) begin
        // A repeated half0 restarts the line with the newer beat.
        w_proto = 1'b1;
        w_cap0  = 1'b1;
      end else begin
        w_state_nxt = IDLE;
        if (ha_bwtag == r_tag) w_complete = 1'b1;
        else                   w_proto    = 1'b1;
      end
    end
  end

  always_ff @(posedge ha_pclock) begin
    if (!ha_preset_n) r_state <= IDLE;
    else              r_state <= w_state_nxt;
  end

  always_ff @(posedge ha_pclock) begin
    if (!ha_preset_n) begin
      r_tag       <= '0;
      r_half0     <= '0;
      r_perr0     <= 1'b0;
      r_proto_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_cap0) begin
        r_tag   <= ha_bwtag;
        r_half0 <= ha_bwdata;
        r_perr0 <= w_beat_perr;
      end
      if (w_proto) r_proto_err <= 1'b1;
      if (w_complete && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign w_pop           = line_ready & ~w_empty;
  assign w_wr_entry.tag  = MAX_TAG_W'(r_tag);
  assign w_wr_entry.data = {r_half0, ha_bwdata};
  assign w_wr_entry.perr = r_perr0 | w_beat_perr;

  psl_sync_fifo #(
    .WIDTH ($bits(line_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (ha_pclock),
    .rst_n   (ha_preset_n),
    .i_push  (w_complete),
    .i_din   (w_wr_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  logic w_unused_tag;
  assign w_unused_tag = ^w_head.tag;
  assign line_valid   = ~w_empty;
  assign line_tag     = w_empty ? '0 : w_head.tag[TAG_W-1:0];
  assign line_data    = w_empty ? '0 : w_head.data;
  assign overflow     = r_overflow;
  assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_psl_bw_line_assembler.sv
// Bench for psl_bw_line_assembler: table vectors, directed corner sequences,
// and a random run against a queue-based line model.
module tb_psl_bw_line_assembler;

  localparam int DEPTH = 4;
  localparam int TAG_W = 8;
`ifdef PSL_BW_PARITY_CHECK_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           bwvalid;
  logic [7:0]     bwtag;
  logic           bwtagpar;
  logic [5:0]     bwad;
  logic [0:511]   bwdata;
  logic [0:7]     bwpar;
  logic           lvalid, lready, lperr, ovf, perr_proto;
  logic [7:0]     ltag;
  logic [0:1023]  ldata;
  logic [2:0]     fcount;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  psl_bw_line_assembler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .ha_pclock(clk), .ha_preset_n(rst_n), .ha_bwvalid(bwvalid),
    .ha_bwtag(bwtag), .ha_bwtagpar(bwtagpar), .ha_bwad(bwad),
    .ha_bwdata(bwdata), .ha_bwpar(bwpar), .line_valid(lvalid),
    .line_ready(lready), .line_tag(ltag), .line_data(ldata),
    .line_perr(lperr), .fifo_count(fcount), .overflow(ovf),
    .proto_err(perr_proto)
  );

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] tag; logic [0:1023] data; logic perr; } line_t;
  line_t        mq[$];
  logic         m_h1, m_p0, m_proto, m_ovf;
  logic [7:0]   m_tag;
  logic [0:511] m_h0;

  function automatic logic beat_bad(logic [0:511] d, logic [0:7] p, logic [7:0] t, logic tp);
    logic bad = 1'b0;
    if (PE) begin
      if ((($countones(t) + int'(tp)) % 2) == 0) bad = 1'b1;
      for (int w = 0; w < 8; w++)
        if ((($countones(d[64*w +: 64]) + int'(p[w])) % 2) == 0) bad = 1'b1;
    end
    return bad;
  endfunction

  task automatic model_step();
    logic  pop, done;
    line_t ln;
    if (!rst_n) begin
      mq.delete(); m_h1 = 0; m_proto = 0; m_ovf = 0; m_p0 = 0;
      return;
    end
    pop  = (mq.size() > 0) && lready;
    done = 0;
    if (bwvalid) begin
      if (bwad > 1) m_proto = 1;
      else if (bwad == 0) begin
        if (m_h1) m_proto = 1;
        m_h1 = 1; m_tag = bwtag; m_h0 = bwdata;
        m_p0 = beat_bad(bwdata, bwpar, bwtag, bwtagpar);
      end else if (!m_h1) m_proto = 1;
      else begin
        m_h1 = 0;
        if (bwtag == m_tag) begin
          done = 1;
          ln.tag = m_tag; ln.data = {m_h0, bwdata};
          ln.perr = m_p0 | beat_bad(bwdata, bwpar, bwtag, bwtagpar);
        end else m_proto = 1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (done) begin
      if (mq.size() < DEPTH) mq.push_back(ln);
      else m_ovf = 1;
    end
  endtask

  task automatic chk(string nm, logic [1023:0] act, logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_check();
    chk("m_valid", lvalid, mq.size() != 0);
    chk("m_count", fcount, mq.size());
    chk("m_ovf", ovf, m_ovf);
    chk("m_proto", perr_proto, m_proto);
    if (mq.size() != 0) begin
      chk("m_tag", ltag, mq[0].tag);
      chk("m_data", ldata, mq[0].data);
      chk("m_perr", lperr, mq[0].perr);
    end else begin
      chk("m_tag0", ltag, 0);
      chk("m_data0", ldata, 0);
      chk("m_perr0", lperr, 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic set_in(logic v, logic [7:0] t, logic [5:0] a, logic [0:511] d,
                        int flipw, logic flipt, logic r);
    bwvalid = v; bwtag = t; bwad = a; bwdata = d; lready = r;
    for (int w = 0; w < 8; w++) bwpar[w] = ~^d[64*w +: 64] ^ (flipw == w);
    bwtagpar = ~^t ^ flipt;
  endtask

  task automatic idle(logic r);
    set_in(0, 0, 0, '0, -1, 0, r);
  endtask

  task automatic do_reset();
    idle(0); rst_n = 0; cycle(); rst_n = 1;
  endtask

  task automatic send_line(logic [7:0] t, logic [7:0] b0, logic [7:0] b1, logic r0, logic r1);
    set_in(1, t, 0, {64{b0}}, -1, 0, r0); cycle();
    set_in(1, t, 1, {64{b1}}, -1, 0, r1); cycle();
  endtask

  function automatic logic [0:511] rand_half();
    logic [0:511] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  // ---------------- table vectors ----------------
  typedef struct {
    logic v; logic [7:0] tag; logic [5:0] ad; logic [7:0] b; int flipw; logic flipt; logic rdy;
    logic e_valid; int e_cnt; logic [7:0] e_tag; logic [7:0] e_b0, e_b1; logic e_perr; logic e_proto;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] tag, logic [5:0] ad, logic [7:0] b, int fw,
                              logic ft, logic rdy, logic ev, int ec, logic [7:0] et,
                              logic [7:0] e0, logic [7:0] e1, logic ep, logic epr);
    vec_t x;
    x.v = v; x.tag = tag; x.ad = ad; x.b = b; x.flipw = fw; x.flipt = ft; x.rdy = rdy;
    x.e_valid = ev; x.e_cnt = ec; x.e_tag = et; x.e_b0 = e0; x.e_b1 = e1;
    x.e_perr = ep; x.e_proto = epr;
    return x;
  endfunction

  vec_t tbl[14];

  initial begin
    tbl[0]  = mk(1, 8'h12, 0, 8'hA5, -1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 8'h12, 1, 8'h5A, -1, 0, 0,  1, 1, 8'h12, 8'hA5, 8'h5A, 0, 0);
    tbl[2]  = mk(0, 8'h00, 0, 8'h00, -1, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 8'h33, 1, 8'h77, -1, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(1, 8'h03, 0, 8'h11, -1, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(1, 8'h04, 1, 8'h22, -1, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(1, 8'h05, 0, 8'h11, -1, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(1, 8'h05, 1, 8'h22, -1, 0, 0,  1, 1, 8'h05, 8'h11, 8'h22, 0, 1);
    tbl[8]  = mk(1, 8'h20, 0, 8'h33, -1, 0, 1,  0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(1, 8'h20, 1, 8'h44,  3, 0, 0,  1, 1, 8'h20, 8'h33, 8'h44, PE, 1);
    tbl[10] = mk(1, 8'h00, 5, 8'h00, -1, 0, 1,  0, 0, 0, 0, 0, 0, 1);
    tbl[11] = mk(1, 8'h41, 0, 8'h55, -1, 1, 0,  0, 0, 0, 0, 0, 0, 1);
    tbl[12] = mk(1, 8'h41, 1, 8'h66, -1, 0, 0,  1, 1, 8'h41, 8'h55, 8'h66, PE, 1);
    tbl[13] = mk(0, 8'h00, 0, 8'h00, -1, 0, 1,  0, 0, 0, 0, 0, 0, 1);

    rst_n = 0; idle(0);
    repeat (2) cycle();
    rst_n = 1;
    chk("rst_valid", lvalid, 0);
    chk("rst_count", fcount, 0);
    chk("rst_flags", {ovf, perr_proto, lperr}, 0);
    chk("rst_tag", ltag, 0);

    // table: capture, protocol faults, parity
    foreach (tbl[i]) begin
      set_in(tbl[i].v, tbl[i].tag, tbl[i].ad, {64{tbl[i].b}}, tbl[i].flipw, tbl[i].flipt, tbl[i].rdy);
      cycle();
      chk($sformatf("t%0d_valid", i), lvalid, tbl[i].e_valid);
      chk($sformatf("t%0d_cnt", i), fcount, tbl[i].e_cnt);
      chk($sformatf("t%0d_proto", i), perr_proto, tbl[i].e_proto);
      if (tbl[i].e_valid) begin
        chk($sformatf("t%0d_tag", i), ltag, tbl[i].e_tag);
        chk($sformatf("t%0d_data", i), ldata, {{64{tbl[i].e_b0}}, {64{tbl[i].e_b1}}});
        chk($sformatf("t%0d_perr", i), lperr, tbl[i].e_perr);
      end
    end

    // fill and overflow: tags 0..4 with no consumer
    do_reset();
    for (int t = 0; t < 5; t++) send_line(8'(t), 8'(t + 1), 8'(t + 8'h80), 0, 0);
    idle(0);
    chk("fill_count", fcount, 4);
    chk("fill_ovf", ovf, 1);
    chk("fill_head", ltag, 0);
    idle(1);
    for (int t = 0; t < 4; t++) begin
      chk("drain_valid", lvalid, 1);
      chk("drain_tag", ltag, t);
      cycle();
    end
    chk("drain_empty", lvalid, 0);

    // push and pop on the same edge while full
    do_reset();
    for (int t = 0; t < 4; t++) send_line(8'(8'h10 + t), 8'hC0, 8'(t), 0, 0);
    set_in(1, 8'h09, 0, {64{8'hE1}}, -1, 0, 0); cycle();
    set_in(1, 8'h09, 1, {64{8'hE2}}, -1, 0, 1); cycle();
    chk("fb_count", fcount, 4);
    chk("fb_ovf", ovf, 0);
    chk("fb_head", ltag, 8'h11);
    idle(1);
    cycle(); cycle(); cycle();
    chk("fb_tail_tag", ltag, 8'h09);
    chk("fb_tail_data", ldata, {{64{8'hE1}}, {64{8'hE2}}});
    cycle();
    chk("fb_empty", lvalid, 0);

    // reset in the middle of a line
    do_reset();
    send_line(8'h66, 8'h01, 8'h02, 0, 0);
    set_in(1, 8'h77, 0, {64{8'h99}}, -1, 0, 0); cycle();
    idle(0); rst_n = 0; cycle(); rst_n = 1;
    chk("mr_count", fcount, 0);
    chk("mr_outs", {lvalid, ltag, lperr, ovf, perr_proto}, 0);
    chk("mr_data", ldata, 0);
    set_in(1, 8'h77, 1, {64{8'h98}}, -1, 0, 0); cycle();
    chk("mr_proto", perr_proto, 1);
    chk("mr_nopush", fcount, 0);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [5:0] a;
      int r = $urandom_range(0, 99);
      a = (r < 45) ? 6'd0 : (r < 92) ? 6'd1 : 6'($urandom_range(2, 63));
      set_in($urandom_range(0, 9) < 7, 8'($urandom_range(0, 3)), a, rand_half(),
             ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1,
             $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1);
      rst_n = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst_n = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
